// File: rtl/lc3_pkg.sv
// lc3_pkg: state numbers, mux/ALU encodings, opcodes and control bundle shared by the LC-3 sequencer
package lc3_pkg;
  typedef enum logic [5:0] {
    S_BR = 6'd0, S_ADD = 6'd1, S_LD_ADDR = 6'd2, S_ST_ADDR = 6'd3, S_AND = 6'd5,
    S_NOT = 6'd9, S_JMP = 6'd12, S_ILLEGAL = 6'd13, S_LEA = 6'd14, S_ST_MEM = 6'd16,
    S_FETCH1 = 6'd18, S_BR_TAKE = 6'd22, S_ST_DATA = 6'd23, S_LD_MEM = 6'd25,
    S_LD_WB = 6'd27, S_DECODE = 6'd32, S_FETCH2 = 6'd33, S_FETCH3 = 6'd35
  } state_e;
  localparam logic [1:0] ALUK_ADD = 2'b00, ALUK_AND = 2'b01, ALUK_NOT = 2'b10, ALUK_PASSA = 2'b11;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;
  localparam logic [1:0] ADDR2_SEXT9 = 2'b10;
  localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_LD = 4'b0010, OP_ST = 4'b0011,
                         OP_AND = 4'b0101, OP_NOT = 4'b1001, OP_JMP = 4'b1100, OP_LEA = 4'b1110;
  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] aluk, pcmux;
    logic addr1mux;
    logic [1:0] addr2mux;
    logic sr1mux, marmux, mio_en, r_w, instr_done, illegal;
  } ctrl_t;
  function automatic state_e decode_state(input logic [3:0] op);
    case (op)
      OP_ADD:  return S_ADD;
      OP_AND:  return S_AND;
      OP_NOT:  return S_NOT;
      OP_BR:   return S_BR;
      OP_LEA:  return S_LEA;
      OP_LD:   return S_LD_ADDR;
      OP_ST:   return S_ST_ADDR;
      OP_JMP:  return S_JMP;
      default: return S_ILLEGAL;
    endcase
  endfunction
endpackage

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore fetch/decode/execute sequencer driving LC-3 datapath loads, gates and mux selects
module lc3_control_fsm
  import lc3_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IR,
  input  logic        BEN,
  input  logic        R,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        LD_PC,
  output logic        GATE_PC,
  output logic        GATE_MDR,
  output logic        GATE_ALU,
  output logic        GATE_MARMUX,
  output logic [1:0]  ALUK,
  output logic [1:0]  PCMUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic        SR1MUX,
  output logic        MARMUX,
  output logic        MIO_EN,
  output logic        R_W,
  output logic        INSTR_DONE,
  output logic        ILLEGAL,
  output logic [5:0]  STATE
);
  state_e state, nxt;
  ctrl_t c, o;
  always_ff @(posedge CLK) state <= RESET ? S_FETCH1 : nxt;
  always_comb begin
    c = '0;
    nxt = state;
    case (state)
      S_FETCH1: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; nxt = S_FETCH2; end
      S_FETCH2: begin c.mio_en = 1'b1; c.ld_mdr = 1'b1; nxt = R ? S_FETCH3 : S_FETCH2; end
      S_FETCH3: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; nxt = S_DECODE; end
      S_DECODE: begin c.ld_ben = 1'b1; nxt = decode_state(IR[15:12]); end
      S_ADD, S_AND, S_NOT: begin
        c.sr1mux = 1'b1;
        c.aluk = state == S_ADD ? ALUK_ADD : state == S_AND ? ALUK_AND : ALUK_NOT;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.instr_done = 1'b1;
        nxt = S_FETCH1;
      end
      S_BR: begin c.instr_done = !BEN; nxt = BEN ? S_BR_TAKE : S_FETCH1; end
      S_BR_TAKE: begin
        c.addr2mux = ADDR2_SEXT9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; c.instr_done = 1'b1;
        nxt = S_FETCH1;
      end
      S_LEA: begin
        c.addr2mux = ADDR2_SEXT9; c.marmux = 1'b1; c.gate_marmux = 1'b1; c.ld_reg = 1'b1;
        c.instr_done = 1'b1; nxt = S_FETCH1;
      end
      S_LD_ADDR, S_ST_ADDR: begin
        c.addr2mux = ADDR2_SEXT9; c.marmux = 1'b1; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
        nxt = state == S_LD_ADDR ? S_LD_MEM : S_ST_DATA;
      end
      S_LD_MEM: begin c.mio_en = 1'b1; c.ld_mdr = 1'b1; nxt = R ? S_LD_WB : S_LD_MEM; end
      S_LD_WB: begin
        c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.instr_done = 1'b1; nxt = S_FETCH1;
      end
      S_ST_DATA: begin c.aluk = ALUK_PASSA; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; nxt = S_ST_MEM; end
      S_ST_MEM: begin c.mio_en = 1'b1; c.r_w = 1'b1; c.instr_done = R; nxt = R ? S_FETCH1 : S_ST_MEM; end
      S_JMP: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
        c.instr_done = 1'b1; nxt = S_FETCH1;
      end
      S_ILLEGAL: begin c.illegal = 1'b1; c.instr_done = 1'b1; nxt = S_FETCH1; end
      default: nxt = S_FETCH1;
    endcase
  end
  // Reset silences every control immediately so an in-flight memory access is abandoned.
  assign o = RESET ? '0 : c;
  assign STATE = RESET ? S_FETCH1 : state;
  assign LD_MAR = o.ld_mar;
  assign LD_MDR = o.ld_mdr;
  assign LD_IR = o.ld_ir;
  assign LD_BEN = o.ld_ben;
  assign LD_REG = o.ld_reg;
  assign LD_CC = o.ld_cc;
  assign LD_PC = o.ld_pc;
  assign GATE_PC = o.gate_pc;
  assign GATE_MDR = o.gate_mdr;
  assign GATE_ALU = o.gate_alu;
  assign GATE_MARMUX = o.gate_marmux;
  assign ALUK = o.aluk;
  assign PCMUX = o.pcmux;
  assign ADDR1MUX = o.addr1mux;
  assign ADDR2MUX = o.addr2mux;
  assign SR1MUX = o.sr1mux;
  assign MARMUX = o.marmux;
  assign MIO_EN = o.mio_en;
  assign R_W = o.r_w;
  assign INSTR_DONE = o.instr_done;
  assign ILLEGAL = o.illegal;
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: micro-op queue model checked every cycle, plus directed instruction runs with literal expectations
module tb_lc3_control_fsm;
  logic CLK = 1'b0, RESET = 1'b1, BEN = 1'b0, R = 1'b1;
  logic [15:0] IR = 16'h1042;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
  logic GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX;
  logic [1:0] ALUK, PCMUX, ADDR2MUX;
  logic ADDR1MUX, SR1MUX, MARMUX, MIO_EN, R_W, INSTR_DONE, ILLEGAL;
  logic [5:0] STATE;

  lc3_control_fsm dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .BEN(BEN), .R(R),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_REG(LD_REG),
    .LD_CC(LD_CC), .LD_PC(LD_PC), .GATE_PC(GATE_PC), .GATE_MDR(GATE_MDR), .GATE_ALU(GATE_ALU),
    .GATE_MARMUX(GATE_MARMUX), .ALUK(ALUK), .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .SR1MUX(SR1MUX), .MARMUX(MARMUX), .MIO_EN(MIO_EN), .R_W(R_W),
    .INSTR_DONE(INSTR_DONE), .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  initial forever #5 CLK = ~CLK;

  localparam logic [23:0] M_ILL = 24'h1, M_DONE = 24'h2, M_RW = 24'h4, M_MIO = 24'h8,
    M_MARMUX = 24'h10, M_SR1 = 24'h20, M_A2OFF9 = 24'h80, M_A1BASE = 24'h100,
    M_PCADDER = 24'h400, M_AK_AND = 24'h800, M_AK_NOT = 24'h1000, M_AK_PASS = 24'h1800,
    M_G_MARMUX = 24'h2000, M_G_ALU = 24'h4000, M_G_MDR = 24'h8000, M_G_PC = 24'h10000,
    M_LD_PC = 24'h20000, M_LD_CC = 24'h40000, M_LD_REG = 24'h80000, M_LD_BEN = 24'h100000,
    M_LD_IR = 24'h200000, M_LD_MDR = 24'h400000, M_LD_MAR = 24'h800000;
  localparam int K_PLAIN = 0, K_WAIT = 1, K_WAITDONE = 2, K_BR = 3, K_DEC = 4;

  logic [23:0] act;
  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC, GATE_PC, GATE_MDR,
                GATE_ALU, GATE_MARMUX, ALUK, PCMUX, ADDR1MUX, ADDR2MUX, SR1MUX, MARMUX,
                MIO_EN, R_W, INSTR_DONE, ILLEGAL};

  int n_cmp = 0, n_bad = 0;

  typedef struct {int st; logic [23:0] cw; int kind;} step_t;
  step_t q[$];

  function automatic step_t mk(input int st, input logic [23:0] cw, input int kind);
    step_t s;
    s.st = st; s.cw = cw; s.kind = kind;
    return s;
  endfunction

  // Each instruction is a list of micro-steps appended once DECODE has been consumed.
  function automatic void push_instr(input logic [3:0] op);
    case (op)
      4'b0001: q.push_back(mk(1, M_SR1 | M_G_ALU | M_LD_REG | M_LD_CC | M_DONE, K_PLAIN));
      4'b0101: q.push_back(mk(5, M_SR1 | M_AK_AND | M_G_ALU | M_LD_REG | M_LD_CC | M_DONE, K_PLAIN));
      4'b1001: q.push_back(mk(9, M_SR1 | M_AK_NOT | M_G_ALU | M_LD_REG | M_LD_CC | M_DONE, K_PLAIN));
      4'b0000: q.push_back(mk(0, 24'h0, K_BR));
      4'b1110: q.push_back(mk(14, M_A2OFF9 | M_MARMUX | M_G_MARMUX | M_LD_REG | M_DONE, K_PLAIN));
      4'b0010: begin
        q.push_back(mk(2, M_A2OFF9 | M_MARMUX | M_G_MARMUX | M_LD_MAR, K_PLAIN));
        q.push_back(mk(25, M_MIO | M_LD_MDR, K_WAIT));
        q.push_back(mk(27, M_G_MDR | M_LD_REG | M_LD_CC | M_DONE, K_PLAIN));
      end
      4'b0011: begin
        q.push_back(mk(3, M_A2OFF9 | M_MARMUX | M_G_MARMUX | M_LD_MAR, K_PLAIN));
        q.push_back(mk(23, M_AK_PASS | M_G_ALU | M_LD_MDR, K_PLAIN));
        q.push_back(mk(16, M_MIO | M_RW, K_WAITDONE));
      end
      4'b1100: q.push_back(mk(12, M_SR1 | M_A1BASE | M_PCADDER | M_LD_PC | M_DONE, K_PLAIN));
      default: q.push_back(mk(13, M_ILL | M_DONE, K_PLAIN));
    endcase
  endfunction

  always @(negedge CLK) begin
    logic [23:0] e;
    int est;
    step_t s;
    if (RESET) begin
      q.delete();
      e = '0;
      est = 18;
    end else begin
      if (q.size() == 0) begin
        q.push_back(mk(18, M_G_PC | M_LD_MAR | M_LD_PC, K_PLAIN));
        q.push_back(mk(33, M_MIO | M_LD_MDR, K_WAIT));
        q.push_back(mk(35, M_G_MDR | M_LD_IR, K_PLAIN));
        q.push_back(mk(32, M_LD_BEN, K_DEC));
      end
      s = q[0];
      est = s.st;
      e = s.cw | (((s.kind == K_WAITDONE && R) || (s.kind == K_BR && !BEN)) ? M_DONE : 24'h0);
    end
    n_cmp++;
    if (STATE !== est[5:0] || act !== e) begin
      n_bad++;
      $display("FAIL model t=%0t: state %0d ctrl %h, required state %0d ctrl %h", $time, STATE, act, est, e);
    end
    n_cmp++;
    if ($countones({GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX}) > 1) begin
      n_bad++;
      $display("FAIL gates t=%0t: %b, required at most one high", $time, {GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX});
    end
    if (!RESET && !((s.kind == K_WAIT || s.kind == K_WAITDONE) && !R)) begin
      q.delete(0);
      if (s.kind == K_DEC) push_instr(IR[15:12]);
      if (s.kind == K_BR && BEN) q.push_back(mk(22, M_A2OFF9 | M_PCADDER | M_LD_PC | M_DONE, K_PLAIN));
    end
  end

  int exp_seq[$];

  task automatic check(input string name, input bit ok, input string got, input string want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, required %s", name, got, want);
    end
  endtask

  // Reset for two cycles, then run one instruction until the FSM re-enters FETCH1.
  task automatic run(input string name, input logic [15:0] ir, input logic ben, input int wst,
                     input int nw, input int done_st, input int pin_i, input logic [23:0] pin_v);
    int log[$];
    logic [23:0] cwl[$];
    int dn = 0, dst = -1, w = nw, st;
    bit fin = 0, ok;
    string sg = "", sw = "";
    RESET = 1'b1; IR = ir; BEN = ben; R = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check({name, "_reset"}, act === 24'h0 && STATE === 6'd18,
          $sformatf("ctrl %h state %0d", act, STATE), "ctrl 000000 state 18");
    RESET = 1'b0;
    for (int c = 0; c < 40; c++) begin
      st = int'(STATE);
      if (log.size() > 0 && st == 18) begin fin = 1; break; end
      log.push_back(st);
      R = !(st == wst && w > 0);
      if (!R) w--;
      #1;
      cwl.push_back(act);
      if (INSTR_DONE) begin dn++; dst = st; end
      @(posedge CLK);
      #1;
    end
    ok = fin && log.size() == exp_seq.size();
    foreach (log[i]) begin
      sg = {sg, $sformatf("%0d ", log[i])};
      if (i < exp_seq.size() && log[i] != exp_seq[i]) ok = 0;
    end
    foreach (exp_seq[i]) sw = {sw, $sformatf("%0d ", exp_seq[i])};
    check({name, "_seq"}, ok, {sg, fin ? "" : "(timeout)"}, sw);
    check({name, "_done"}, dn == 1 && dst == done_st,
          $sformatf("%0d pulses last in %0d", dn, dst), $sformatf("1 pulse in %0d", done_st));
    if (pin_i >= 0)
      check({name, "_pin"}, pin_i < cwl.size() && cwl[pin_i] === pin_v,
            pin_i < cwl.size() ? $sformatf("%h", cwl[pin_i]) : "missing", $sformatf("%h", pin_v));
  endtask

  initial begin
    bit found = 0;
    exp_seq = {18, 33, 35, 32, 1};
    run("add", 16'h1042, 1'b0, -1, 0, 1, 4, 24'h0C4022);
    exp_seq = {18, 33, 35, 32, 2, 25, 25, 25, 25, 27};
    run("ld_wait", 16'h2005, 1'b0, 25, 3, 27, 5, 24'h400008);
    exp_seq = {18, 33, 35, 32, 0, 22};
    run("br_taken", 16'h0E05, 1'b1, -1, 0, 22, 5, 24'h020482);
    exp_seq = {18, 33, 35, 32, 0};
    run("br_not", 16'h0E05, 1'b0, -1, 0, 0, 4, 24'h000002);
    exp_seq = {18, 33, 35, 32, 3, 23, 16};
    run("st", 16'h3005, 1'b0, -1, 0, 16, 5, 24'h405800);
    exp_seq = {18, 33, 35, 32, 13};
    run("illegal", 16'hD000, 1'b0, -1, 0, 13, 4, 24'h000003);
    exp_seq = {18, 33, 35, 32, 5};
    run("and", 16'h5042, 1'b0, -1, 0, 5, -1, 24'h0);
    exp_seq = {18, 33, 35, 32, 9};
    run("not", 16'h907F, 1'b0, -1, 0, 9, -1, 24'h0);
    exp_seq = {18, 33, 35, 32, 14};
    run("lea", 16'hE005, 1'b0, -1, 0, 14, 4, 24'h082092);
    exp_seq = {18, 33, 35, 32, 12};
    run("jmp", 16'hC080, 1'b0, -1, 0, 12, 4, 24'h020522);
    exp_seq = {18, 33, 33, 33, 35, 32, 1};
    run("fetch_wait", 16'h1042, 1'b0, 33, 2, 1, 1, 24'h400008);
    exp_seq = {18, 33, 35, 32, 3, 23, 16, 16, 16};
    run("st_wait", 16'h3005, 1'b0, 16, 2, 16, 6, 24'h00000C);
    exp_seq = {18, 33, 35, 32, 13};
    run("rti", 16'h8000, 1'b0, -1, 0, 13, -1, 24'h0);
    // Reset while a store waits on memory.
    RESET = 1'b1; IR = 16'h3005; BEN = 1'b0; R = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (STATE === 6'd16) begin found = 1; R = 1'b0; break; end
      @(posedge CLK);
      #1;
    end
    @(posedge CLK);
    #1;
    check("mid_wait", found && STATE === 6'd16 && MIO_EN === 1'b1 && R_W === 1'b1,
          $sformatf("state %0d mio %b rw %b", STATE, MIO_EN, R_W), "state 16 mio 1 rw 1");
    RESET = 1'b1;
    #1;
    check("mid_reset", STATE === 6'd18 && MIO_EN === 1'b0 && act === 24'h0,
          $sformatf("state %0d ctrl %h", STATE, act), "state 18 ctrl 000000");
    @(posedge CLK);
    #1 RESET = 1'b0; R = 1'b1;
    #1;
    check("mid_restart", STATE === 6'd18 && act === 24'h830000,
          $sformatf("state %0d ctrl %h", STATE, act), "state 18 ctrl 830000");
    repeat (6) @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lc3_control_fsm.md
# lc3_control_fsm

Moore-style control sequencer for the LC-3 datapath. Each cycle it drives the load enables, bus gates and mux selects for the ALU, the address adder, the PC incrementer and the memory interface. It implements fetch/decode/execute for the operate, branch, LEA, LD, ST and JMP instructions. It replaces hand-driven control in the top-level CPU and sits between the IR/BEN/memory-ready signals and the datapath control inputs.

## Interface
Parameters:
- none (state and select encodings are fixed constants in the shared package)

Ports:
- CLK  in  1  single system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IR  in  16  instruction register contents (datapath-owned)
- BEN  in  1  branch-enable register output (datapath-owned)
- R  in  1  memory ready; a memory access completes in the cycle R=1
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  out  1 each  register load enables
- GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX  out  1 each  bus drivers; at most one high in any cycle
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
- PCMUX  out  2  00 PC+1, 01 BUS, 10 address adder
- ADDR1MUX  out  1  0 PC, 1 BaseR (SR1 output)
- ADDR2MUX  out  2  00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0])
- SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
- MARMUX  out  1  0 ZEXT(IR[7:0]), 1 address adder
- MIO_EN  out  1  memory access request
- R_W  out  1  0 read, 1 write; meaningful only when MIO_EN=1
- INSTR_DONE  out  1  one-cycle pulse in the final execute state of each instruction
- ILLEGAL  out  1  one-cycle pulse when an unsupported opcode is decoded
- STATE  out  6  current state number (debug and verification)

## Operation
- States use LC-3 numbering: 18 FETCH1, 33 FETCH2, 35 FETCH3, 32 DECODE, 1 ADD, 5 AND, 9 NOT, 0 BR, 22 BR_TAKE, 14 LEA, 2 LD_ADDR, 25 LD_MEM, 27 LD_WB, 3 ST_ADDR, 23 ST_DATA, 16 ST_MEM, 12 JMP, 13 ILLEGAL.
- FETCH1 (18): MAR<-PC (GATE_PC, LD_MAR); PC<-PC+1 (PCMUX=00, LD_PC). Next state is 33.
- FETCH2 (33): MDR<-M (MIO_EN, R_W=0, LD_MDR). Stays in 33 while R=0; goes to 35 when R=1.
- FETCH3 (35): IR<-MDR (GATE_MDR, LD_IR). Next state is 32.
- DECODE (32): LD_BEN. Next state is chosen by IR[15:12]: 0001->1, 0101->5, 1001->9, 0000->0, 1110->14, 0010->2, 0011->3, 1100->12, all others->13.
- ADD (1) and AND (5): SR1MUX=1, ALUK=00 or 01 respectively, GATE_ALU, LD_REG, LD_CC. Next state is 18.
- NOT (9): same as ADD/AND but with ALUK=10. Next state is 18.
- BR (0): if BEN=1, next state is 22; else next state is 18 (and INSTR_DONE pulses).
- BR_TAKE (22): ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC. Next state is 18.
- LEA (14): ADDR1MUX=0, ADDR2MUX=10, MARMUX=1, GATE_MARMUX, LD_REG. LD_CC is not asserted. Next state is 18.
- LD_ADDR (2): MAR<-PC+off9 (ADDR1MUX=0, ADDR2MUX=10, MARMUX=1, GATE_MARMUX, LD_MAR). Next state is 25.
- LD_MEM (25): same as state 33; waits on R. Next state is 27.
- LD_WB (27): GATE_MDR, LD_REG, LD_CC. Next state is 18.
- ST_ADDR (3): same controls as state 2. Next state is 23.
- ST_DATA (23): SR1MUX=0, ALUK=11, GATE_ALU, LD_MDR. Next state is 16.
- ST_MEM (16): MIO_EN, R_W=1. Stays in 16 while R=0; goes to 18 when R=1.
- JMP (12): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC. Next state is 18.
- ILLEGAL (13): ILLEGAL=1, no loads. Next state is 18 (skip-and-continue).
- INSTR_DONE asserts in states 1, 5, 9, 22, 14, 27, 12, 13; in state 16 when R=1; and in state 0 when BEN=0.
- Every control output not listed for a state is 0.

## Timing
- All outputs are decoded from the state register. The exceptions are the INSTR_DONE qualifiers in states 0 and 16, which also depend on BEN and R.
- Reset value: RESET=1 at an edge loads state 18. While RESET=1, every output except STATE is forced to 0, so no loads or memory requests are issued. STATE reads 18 during reset.
- The first fetch occurs in the first cycle after RESET deasserts. RESET mid-instruction (including during a memory wait) abandons the access with no partial writeback.
- Minimum latency with R=1 on first request: operate/LEA/JMP 5 cycles; BR not taken 5 cycles; BR taken 6 cycles; LD 7 cycles; ST 7 cycles. Each wait cycle with R=0 adds one cycle.
- MIO_EN and R_W stay stable throughout a wait.

## Structure
- Shared package lc3_pkg holds: the state-number constants; the ALUK, PCMUX and ADDR2MUX encodings; and the opcode constants.
- Single module, no sub-modules: a two-process FSM (state register plus combinational next-state/output decode).

## Test plan
- RESET for 2 cycles, IR=0x1042 (ADD R0,R1,R2), R=1 -> STATE sequence 18,33,35,32,1,18; LD_REG and LD_CC high only in state 1 with ALUK=00; all outputs 0 during reset.
- LD with R held 0 for 3 cycles in state 25 -> state 25 persists 4 cycles with MIO_EN=1, R_W=0; LD_WB follows; total 10 cycles.
- BR 0x0E05 with BEN=1 -> 0 then 22 with PCMUX=10, ADDR2MUX=10; with BEN=0 -> 0 then 18, and INSTR_DONE pulses in state 0.
- ST 0x3005, R=1 -> 3, 23 (ALUK=11, LD_MDR), 16 (MIO_EN=1, R_W=1), 18.
- IR=0xD000 (unsupported opcode) -> state 13 with ILLEGAL=1 for one cycle, then back to 18.
- RESET asserted while in state 16 with R=0 -> next STATE is 18, MIO_EN drops the same cycle, and there is no LD_REG or LD_PC before the fetch restarts.
